// File: rtl/rv32_pkg.sv
// rv32_pkg: shared decode constants and the decoded-instruction bundle for the
// rv32i core. The ALU imports the ALU_* op codes from here, so the encoding the
// decoder emits is the encoding the ALU executes.
//
// Contents:
//   OPC_*          major opcodes recognised by the decode stage
//   F3_* / F7_*    funct3 / funct7 selectors
//   ALU_*          4-bit ALU operation codes
//   decode_bundle_t packed bundle registered by the decode stage
//   sext_i_imm()   sign-extends the I-type immediate field
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_DIV     = 3'b100;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1101;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_ops;
    logic            is_lui;
    logic            is_i_type;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } decode_bundle_t;

  function automatic logic [31:0] sext_i_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/rv32_skid_buffer.sv
// rv32_skid_buffer: one output register plus one skid register (2 entries).
// in_ready is the inverted skid-full flop, so it never depends combinationally
// on out_ready.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears data too)
//   flush          empties both entries; an input offered this cycle is dropped
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake, out_data is registered
module rv32_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_full;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up this edge. The skid entry is older than anything
      // at the input, and in_ready is low while it is full, so no input can
      // be lost here.
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_valid) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid && !skid_full) begin
      // Output is held: park the new entry in the skid register.
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered instruction decode for the rv32i core.
// Decodes the incoming instruction combinationally and registers the result
// through a 2-entry skid buffer. Illegal encodings still produce a bundle,
// with illegal=1 and all control/immediate fields zeroed.
//
// Build option:
//   DECODE_RV32M_EN  when defined, decodes funct7=0000001 MUL (f3=000) and
//                    DIV (f3=100); otherwise every funct7=0000001 is illegal.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        drop held and inbound instructions
//   in_valid/in_ready            fetch handshake; in_inst, in_pc payload
//   out_valid/out_ready          ALU-side handshake
//   out_pc                       PC of the decoded instruction
//   alu_ops, is_lui, is_i_type, imm   ALU control bundle
//   rs1_addr, rs2_addr, rd_addr, rd_we  register file controls
//   illegal                      undecodable instruction
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      alu_ops,
  output logic            is_lui,
  output logic            is_i_type,
  output logic [31:0]     imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  localparam int BW = $bits(decode_bundle_t);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  decode_bundle_t dec;
  decode_bundle_t held;
  logic [BW-1:0]  held_bits;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    dec         = '0;
    dec.pc      = XLEN'(in_pc);
    dec.rd      = in_inst[11:7];
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              F3_ADD_SUB: dec.alu_ops = ALU_ADD;
              F3_SLL:     dec.alu_ops = ALU_SLL;
              F3_XOR:     dec.alu_ops = ALU_XOR;
              F3_SRL:     dec.alu_ops = ALU_SRL;
              F3_OR:      dec.alu_ops = ALU_OR;
              F3_AND:     dec.alu_ops = ALU_AND;
              default:    dec.illegal = 1'b1;
            endcase
          end
          F7_ALT: begin
            if (funct3 == F3_ADD_SUB) dec.alu_ops = ALU_SUB;
            else                      dec.illegal = 1'b1;
          end
          F7_MULDIV: begin
`ifdef DECODE_RV32M_EN
            if      (funct3 == F3_MUL) dec.alu_ops = ALU_MUL;
            else if (funct3 == F3_DIV) dec.alu_ops = ALU_DIV;
            else                       dec.illegal = 1'b1;
`else
            dec.illegal = 1'b1;
`endif
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADDI) begin
          dec.alu_ops   = ALU_ADD;
          dec.is_i_type = 1'b1;
          dec.imm       = sext_i_imm(in_inst);
          dec.rs2       = 5'd0;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        // The ALU performs the <<12; we hand it the raw upper-20 field.
        dec.is_lui = 1'b1;
        dec.imm    = {12'b0, in_inst[31:12]};
        dec.rs1    = 5'd0;
        dec.rs2    = 5'd0;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.alu_ops   = ALU_ADD;
      dec.is_lui    = 1'b0;
      dec.is_i_type = 1'b0;
      dec.imm       = '0;
    end

    dec.rd_we = !dec.illegal && (dec.rd != 5'd0);
  end

  rv32_skid_buffer #(
    .WIDTH(BW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (held_bits)
  );

  assign held      = decode_bundle_t'(held_bits);
  assign out_pc    = PC_W'(held.pc);
  assign alu_ops   = held.alu_ops;
  assign is_lui    = held.is_lui;
  assign is_i_type = held.is_i_type;
  assign imm       = held.imm;
  assign rs1_addr  = held.rs1;
  assign rs2_addr  = held.rs2;
  assign rd_addr   = held.rd;
  assign rd_we     = held.rd_we;
  assign illegal   = held.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
module tb_rv32_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        lui;
    logic        ityp;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_ops;
  logic        is_lui;
  logic        is_i_type;
  logic [31:0] imm;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  exp_t actual;
  exp_t prev_bundle;
  logic prev_hold = 1'b0;

  rv32_decode_stage #(.PC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .alu_ops  (alu_ops),
    .is_lui   (is_lui),
    .is_i_type(is_i_type),
    .imm      (imm),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_we    (rd_we),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign actual = '{pc: out_pc, alu: alu_ops, lui: is_lui, ityp: is_i_type, imm: imm,
                    rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, we: rd_we, ill: illegal};

  task automatic chk(input logic ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decoder, written straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t r;
    int   op, f3, f7;
    int   base_tab[8] = '{0, 5, -1, -1, 2, 6, 3, 4};
    op = int'(inst[6:0]);
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    r = '0;
    r.pc  = pc;
    r.rd  = inst[11:7];
    r.rs1 = inst[19:15];
    r.rs2 = inst[24:20];
    r.ill = 1'b1;
    if (op == 'h33) begin
      if (f7 == 0 && base_tab[f3] >= 0) begin
        r.alu = 4'(base_tab[f3]);
        r.ill = 1'b0;
      end else if (f7 == 'h20 && f3 == 0) begin
        r.alu = 4'd1;
        r.ill = 1'b0;
      end
`ifdef DECODE_RV32M_EN
      else if (f7 == 1 && f3 == 0) begin
        r.alu = 4'd12;
        r.ill = 1'b0;
      end else if (f7 == 1 && f3 == 4) begin
        r.alu = 4'd13;
        r.ill = 1'b0;
      end
`endif
    end else if (op == 'h13 && f3 == 0) begin
      r.ityp = 1'b1;
      r.imm  = 32'($signed(inst[31:20]));
      r.rs2  = 5'd0;
      r.ill  = 1'b0;
    end else if (op == 'h37) begin
      r.lui = 1'b1;
      r.imm = inst >> 12;
      r.rs1 = 5'd0;
      r.rs2 = 5'd0;
      r.ill = 1'b0;
    end
    r.we = !r.ill && (r.rd != 0);
    return r;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    int          k, s;
    k   = $urandom_range(0, 9);
    f3  = 3'($urandom);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    if (k <= 3) begin
      s = $urandom_range(0, 5);
      if (s <= 2)      f7 = 7'h00;
      else if (s == 3) f7 = 7'h20;
      else if (s == 4) f7 = 7'h01;
      else             f7 = 7'($urandom);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end else if (k <= 5) begin
      i12 = 12'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = 3'b000;
      return {i12, rs1, f3, rd, 7'b0010011};
    end else if (k <= 7) begin
      return {20'($urandom), rd, 7'b0110111};
    end
    return $urandom;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, i.e. the values the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk(out_valid && (actual == prev_bundle), "hold_stable",
            {40'd0, out_valid, actual}, {40'd0, 1'b1, prev_bundle});
      if (out_valid && out_ready) begin
        chk(sb_q.size() != 0, "unexpected_output", 128'(actual), 128'(sb_q.size()));
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk(actual == e, "bundle", 128'(actual), 128'(e));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_inst, in_pc));
      prev_hold   = out_valid && !out_ready;
      prev_bundle = actual;
    end
  end

  task automatic wait_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(in_ready, name, 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    wait_accept("accept_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk(!out_valid && in_ready && (actual == '0), name,
        {40'd0, out_valid, actual}, 128'd0);
    chk(in_ready, {name, "_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("reset_state");
    @(posedge clk); #1;

    // Directed decode cases
    send(32'h00500093, 32'h0000_1000);
    chk(out_valid, "latency_1", 128'(out_valid), 128'(1));
    send(32'hFFF08093, 32'h0000_1004);
    send(32'h402081B3, 32'h0000_1008);
    send(32'h002081B3, 32'h0000_100C);
    send(32'h123452B7, 32'h0000_1010);
    send(32'h022081B3, 32'h0000_1014);
    send(32'h0220C1B3, 32'h0000_1018);
    send(32'h00000013, 32'h0000_101C);
    send(32'h0000007F, 32'h0000_1020);
    idle(3);
    chk(sb_q.size() == 0, "directed_drained", 128'(sb_q.size()), 128'd0);

    // Back-pressure: two entries fit, the third waits
    out_ready = 1'b0;
    send(32'h00100113, 32'h0000_2000);
    send(32'h00200193, 32'h0000_2004);
    in_valid = 1'b1; in_inst = 32'h00300213; in_pc = 32'h0000_2008;
    repeat (3) begin
      @(negedge clk);
      chk(!in_ready, "third_blocked", 128'(in_ready), 128'(0));
      chk(out_valid, "stall_out_valid", 128'(out_valid), 128'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("third_accept");
    idle(4);
    chk(sb_q.size() == 0, "stall_drained", 128'(sb_q.size()), 128'd0);

    // Flush with two held, plus an inbound instruction that must vanish
    out_ready = 1'b0;
    send(32'h00400293, 32'h0000_3000);
    send(32'h00500313, 32'h0000_3004);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00600393; in_pc = 32'h0000_3008;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk(!out_valid, "flush_out_valid", 128'(out_valid), 128'(0));
    chk(in_ready, "flush_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h00700413, 32'h0000_4000);
    send(32'h008004B7, 32'h0000_4004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("reset_mid_stall");
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Randomised traffic with random back-pressure and occasional flushes
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = gen_inst();
        in_pc    = {$urandom} & 32'hFFFF_FFFC;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 59) == 0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(6);
    chk(sb_q.size() == 0, "final_drained", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
